// File: rtl/pp_fill_ctrl.sv
// Raster-order hole-filling controller: holds each pixel until its right neighbour
// arrives, then fills flagged pixels from a five-candidate neighbourhood.

module getValue #(
  parameter int DWIDTH = 7
) (
  input  logic [DWIDTH+1:0] din_0,
  input  logic [DWIDTH+1:0] din_45,
  input  logic [DWIDTH+1:0] din_90,
  input  logic [DWIDTH+1:0] din_135,
  input  logic [DWIDTH+1:0] din_180,
  output logic [DWIDTH-1:0] dout
);
  logic [DWIDTH+1:0] srt [5];
  logic [DWIDTH+1:0] tmp;

  always_comb begin
    srt[0] = din_0;
    srt[1] = {2'b00, din_45[DWIDTH-1:0]};
    srt[2] = din_90;
    srt[3] = din_135;
    srt[4] = din_180;
    tmp    = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4 - i; j++) begin
        if (srt[j] > srt[j+1]) begin
          tmp      = srt[j];
          srt[j]   = srt[j+1];
          srt[j+1] = tmp;
        end
      end
    end
    // occlusion outranks mismatch
    if (din_45[DWIDTH])
      dout = srt[1][DWIDTH-1:0];
    else if (din_45[DWIDTH+1])
      dout = srt[2][DWIDTH-1:0];
    else
      dout = din_45[DWIDTH-1:0];
  end
endmodule

// state | meaning
// EMPTY | no pending pixel; next accepted word is column 0
// RUN   | pixel P pending at col_q, waiting for its right neighbour
// FLUSH | last pixel of the row pending; emitted with R = C
module pp_fill_ctrl #(
  parameter int DWIDTH = 7,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH+1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_disp,
  output logic              out_eol,
  output logic              out_eof
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {EMPTY, RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [DWIDTH+1:0] p_q, p_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DWIDTH-1:0] l_q, l_d;
  logic [DWIDTH-1:0] ul_q, ul_d;
  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] out_disp_q, out_disp_d;
  logic              out_eol_q, out_eol_d;
  logic              out_eof_q, out_eof_d;

  logic [DWIDTH-1:0] row_buf [IMG_W];
  logic [DWIDTH-1:0] buf_rd, u_val, ul_val, r_val, fill_val;
  logic              out_free, accept, emit;

  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = (state_q != FLUSH) && out_free;
  assign accept    = in_valid && in_ready;
  assign buf_rd    = row_buf[col_q];
  assign out_valid = out_valid_q;
  assign out_disp  = out_disp_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;

  // row 0 has no row above; column 0 reuses U for UL
  always_comb begin
    u_val  = (row_q == '0) ? '0 : buf_rd;
    ul_val = (row_q == '0) ? '0 : ((col_q == '0) ? buf_rd : ul_q);
    r_val  = (state_q == FLUSH) ? p_q[DWIDTH-1:0] : in_data[DWIDTH-1:0];
  end

  getValue #(.DWIDTH(DWIDTH)) u_sel (
    .din_0   ({2'b00, l_q}),
    .din_45  (p_q),
    .din_90  ({2'b00, u_val}),
    .din_135 ({2'b00, ul_val}),
    .din_180 ({2'b00, r_val}),
    .dout    (fill_val)
  );

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    col_d       = col_q;
    row_d       = row_q;
    l_d         = l_q;
    ul_d        = ul_q;
    out_valid_d = out_valid_q && !out_ready;
    out_disp_d  = out_disp_q;
    out_eol_d   = out_eol_q;
    out_eof_d   = out_eof_q;
    emit        = 1'b0;
    case (state_q)
      EMPTY: if (accept) begin
        p_d     = in_data;
        col_d   = '0;
        state_d = RUN;
      end
      RUN: if (accept) begin
        emit  = 1'b1;
        p_d   = in_data;
        col_d = col_q + 1'b1;
        if (col_q + 1'b1 == COL_LAST) state_d = FLUSH;
      end
      FLUSH: if (out_free) begin
        emit    = 1'b1;
        state_d = EMPTY;
        row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    if (emit) begin
      out_valid_d = 1'b1;
      out_disp_d  = fill_val;
      out_eol_d   = (state_q == FLUSH);
      out_eof_d   = (state_q == FLUSH) && (row_q == ROW_LAST);
      ul_d        = buf_rd;
      if (state_q == FLUSH)
        l_d = '0;
      else if (p_q[DWIDTH+1:DWIDTH] == 2'b00)
        l_d = p_q[DWIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      p_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      l_q         <= '0;
      ul_q        <= '0;
      out_valid_q <= 1'b0;
      out_disp_q  <= '0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      col_q       <= col_d;
      row_q       <= row_d;
      l_q         <= l_d;
      ul_q        <= ul_d;
      out_valid_q <= out_valid_d;
      out_disp_q  <= out_disp_d;
      out_eol_q   <= out_eol_d;
      out_eof_q   <= out_eof_d;
    end
  end

  // ul_d captures the old entry in the same cycle this overwrites it
  always_ff @(posedge clk) begin
    if (emit) row_buf[col_q] <= fill_val;
  end
endmodule

// File: tb/tb_pp_fill_ctrl.sv
// Scoreboard bench for pp_fill_ctrl on a 4x2 frame: stimulus pushes hand-computed
// expected pixels, an independent monitor pops and compares each output transfer.

module tb_pp_fill_ctrl;
  localparam int DW = 7;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam logic [8:0] OCC = 9'h080;
  localparam logic [8:0] MIS = 9'h100;

  typedef logic [8:0] word_t;
  typedef struct {int disp; bit eol; bit eof;} exp_t;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, out_eol, out_eof;
  logic [8:0]  in_data;
  logic [DW-1:0] out_disp;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  pp_fill_ctrl #(.DWIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_disp(out_disp),
    .out_eol(out_eol), .out_eof(out_eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got %0d expected none", out_disp);
      end else begin
        e = sb.pop_front();
        chk("out_disp", int'(out_disp), e.disp);
        chk("out_eol", int'(out_eol), int'(e.eol));
        chk("out_eof", int'(out_eof), int'(e.eof));
      end
    end
  end

  // caller is at a negedge; returns at the negedge following acceptance
  task automatic send(input word_t w);
    int n;
    n = 0;
    in_data  = w;
    in_valid = 1'b1;
    #1;
    while (!in_ready) begin
      if (n == 100) begin
        n_total++;
        $display("FAIL in_ready_timeout: got 0 expected 1 for word %0d", w);
        break;
      end
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_frame(input int e[8]);
    for (int i = 0; i < 8; i++) sb.push_back('{e[i], (i % 4) == 3, i == 7});
  endtask

  task automatic run_frame(input word_t w[8], input int e[8]);
    push_frame(e);
    for (int i = 0; i < 8; i++) send(w[i]);
    in_valid = 1'b0;
  endtask

  initial begin
    word_t fw[8];
    int    fe[8];
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_disp", int'(out_disp), 0);
    chk("rst_out_eol", int'(out_eol), 0);
    chk("rst_out_eof", int'(out_eof), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);

    // clean stream passes through
    fw = '{10, 11, 12, 13, 20, 21, 22, 23};
    fe = '{10, 11, 12, 13, 20, 21, 22, 23};
    run_frame(fw, fe);

    // occlusion at row 1 col 1: {40,5,30,30,44} -> 2nd smallest 30
    fw = '{30, 30, 30, 30, 40, OCC | 9'd5, 44, 45};
    fe = '{30, 30, 30, 30, 40, 30, 44, 45};
    run_frame(fw, fe);
    // mismatch: median 30
    fw = '{30, 30, 30, 30, 40, MIS | 9'd5, 44, 45};
    run_frame(fw, fe);
    // both flags: occlusion rule
    fw = '{30, 30, 30, 30, 40, OCC | MIS | 9'd5, 44, 45};
    run_frame(fw, fe);

    // row-0 mismatch {0,9,0,0,50} -> 0; row-1 last occluded {3,60,50,50,60} -> 50
    fw = '{MIS | 9'd9, 50, 50, 50, 1, 2, 3, OCC | 9'd60};
    fe = '{0, 50, 50, 50, 1, 2, 3, 50};
    run_frame(fw, fe);

    // flagged pixels must not update L; col1 {0,3,20,10,6} -> 6
    fw = '{10, 20, 30, 40, MIS | 9'd100, MIS | 9'd3, 6, 7};
    fe = '{10, 20, 30, 40, 10, 6, 6, 7};
    run_frame(fw, fe);

    // backpressure: stall 5 cycles while pixel 60 is held at the output
    fw = '{60, 61, 62, 63, 70, 71, 72, 73};
    fe = '{60, 61, 62, 63, 70, 71, 72, 73};
    push_frame(fe);
    send(fw[0]);
    send(fw[1]);
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          #2;
          chk("stall_in_ready", int'(in_ready), 0);
          chk("stall_out_disp", int'(out_disp), 60);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join_none
    for (int i = 2; i < 8; i++) send(fw[i]);
    in_valid = 1'b0;

    // reset after 6 accepted words: pending 91 is dropped
    fe = '{80, 81, 82, 83, 90, 0, 0, 0};
    for (int i = 0; i < 5; i++) sb.push_back('{fe[i], i == 3, 1'b0});
    fw = '{80, 81, 82, 83, 90, 91, 0, 0};
    for (int i = 0; i < 6; i++) send(fw[i]);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_out_valid", int'(out_valid), 0);
    chk("post_rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    fw = '{MIS | 9'd9, 50, 50, 50, 1, 2, 3, OCC | 9'd60};
    fe = '{0, 50, 50, 50, 1, 2, 3, 50};
    run_frame(fw, fe);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pp_fill_ctrl.md
# pp_fill_ctrl

Raster-order hole-filling controller for the post-processing stage. It accepts a stream of flagged disparity words (value plus occlusion and mismatch flags) and holds each pixel until its right neighbour arrives. It then builds the five-candidate neighbourhood (left-valid, centre, up, up-left, right), drives the existing combinational five-way fill selector `getValue`, and streams out filled disparities. It also maintains the previous filled row for the up and up-left candidates.

## Interface
- `DWIDTH`, 7: disparity value width; input word is `DWIDTH+2` bits.
- `IMG_W`, 640: pixels per row (≥2).
- `IMG_H`, 480: rows per frame (≥1).
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: block can accept a word this cycle.
- `in_data` in `DWIDTH+2`: bits `[DWIDTH-1:0]` value; bit `DWIDTH` occlusion; bit `DWIDTH+1` mismatch.
- `out_valid` out 1: filled pixel valid.
- `out_ready` in 1: downstream accepts.
- `out_disp` out `DWIDTH`: filled disparity.
- `out_eol` out 1: qualifies last pixel of a row.
- `out_eof` out 1: qualifies last pixel of a frame.

## Operation
**Transfers**
- Input transfer occurs when `in_valid && in_ready`; output transfer occurs when `out_valid && out_ready`.

**State machine**
- FSM states: EMPTY (no pending pixel), RUN (one pending pixel P at column x), FLUSH (last pixel of row pending, no right neighbour will come).
- EMPTY: accepting column-0 word → store as P, go RUN. No output.
- RUN: accepting word N at column x+1 → emit P (right = N value), P←N.
  - If N is column `IMG_W-1`, go FLUSH.
- FLUSH: `in_ready`=0; emit P with right = P's own value and `out_eol`=1. Go EMPTY.
  - `out_eof`=1 when the row is `IMG_H-1`; row counter then wraps to 0.

**Candidates for pending pixel P at (x,y)**
- C: P value; P's flags select the output.
- L: value of the most recent unflagged pixel earlier in row y; 0 if none. L is cleared on entering EMPTY.
- U: stored filled row buffer at x; 0 when y=0.
- UL: stored filled value at x-1; equals U when x=0; 0 when y=0.
- R: raw value of pixel x+1 regardless of its flags; equals C at x=`IMG_W-1`.

**Selection**
- `getValue` ports are driven as:
  - `din_45` = full P word (flags + value).
  - `din_0` = L.
  - `din_90` = U.
  - `din_135` = UL.
  - `din_180` = R.
  - Upper two bits of the non-45 ports are 0.
- Result rule:
  - Occlusion set → 2nd smallest of the five.
  - Else mismatch set → median.
  - Else C.
  - Occlusion has priority over mismatch.

**Row buffer**
- `IMG_W` × `DWIDTH`, single write per emit. The filled value of column x is written at x when emitted.
- The old contents of x are latched into a UL register before the overwrite, so the next column's UL sees the previous row.
- L updates after each emit: if P is unflagged, L←C.

**Reset**
- `out_valid`=0, `out_disp`=0, `out_eol`=`out_eof`=0, FSM=EMPTY, column and row counters=0, L=0, UL register=0.
- `in_ready`=1 in the first cycle after reset deasserts.
- Row buffer contents are don't-care: row 0 never reads them.

## Timing
- Output is registered; `getValue` is combinational between the candidate registers and the output register.
- Latency: pixel x appears on `out_*` the cycle after pixel x+1 is accepted. The last pixel of a row appears one cycle after entering FLUSH (two cycles after its acceptance).
- `in_ready = (state != FLUSH) && (!out_valid || out_ready)`. An emit overwrites the output register only when it is empty or is being drained in the same cycle.
- `out_valid` holds, and `out_disp`/`out_eol`/`out_eof` stay stable, while `out_ready`=0.
- Sustained throughput is `IMG_W` pixels per `IMG_W+1` cycles, because of one FLUSH bubble per row.
- Reset mid-row or mid-frame: the pending pixel is discarded and the next accepted word is column 0, row 0.

## Test plan
- **Clean stream:** 4×2 frame (`IMG_W`=4, `IMG_H`=2), all words unflagged, values 10,11,12,13 / 20,21,22,23 → output equals input in order. `out_eol` on columns 3, `out_eof` on the final 23. One `in_ready` low cycle per row.
- **Occlusion fill:** row 1 above = 30,30,30,30. Row 1 input 40, occluded(5), 44, 45.
  - Column 1 candidates {L=40, C=5, U=30, UL=30, R=44}, 2nd smallest → 30.
- **Mismatch fill:** same stimulus with the mismatch flag instead → median 30.
  - With both flags set → occlusion rule, 30.
- **Row-0 boundary:** row 0 = mismatch(9), 50, 50, 50.
  - Column 0 candidates {L=0, C=9, U=0, UL=0, R=50} → median 0.
- **Backpressure:** hold `out_ready`=0 for 5 cycles mid-row → `in_ready` drops within 1 cycle, `out_disp` stable. No word is lost or duplicated; the sequence is identical to the no-stall run.
- **Reset mid-frame:** assert `rst` after 6 accepted words for 1 cycle → `out_valid`=0 next cycle, then a fresh 4×2 frame produces correct row-0 behaviour and a correct `out_eof`.
